ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX→MEM pipeline register for the MIPS core, placed between the execute unit and the memory-access stage. It carries the register-writeback, HI/LO and load/store fields forward each cycle. It supports four cycle-level actions: stall-hold, bubble insertion, pipeline flush and advance. It also loops multi-cycle arithmetic state (accumulator and cycle count for madd/msub/div) back to execute while the stage is stalled, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- DATA_W, 32, width of data/address words.
- REGADDR_W, 5, register-file address width.
- ALUOP_W, 8, ALU operation code width.
- CNT_W, 2, multi-cycle step counter width.
- STALL_W, 6, width of the stall vector.
- STAGE_IDX, 3, stall-vector bit owned by this stage; bit STAGE_IDX+1 is the downstream stage. Legal range is 0..STALL_W-2.
- NOP_OP, 0, ALU opcode that marks a bubble.
- PERF_W, 16, stall-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  per-stage stall requests from the control unit.
- flush  in  1  exception/branch flush; kills the stage contents.
- ex_valid  in  1  execute-stage instruction valid.
- ex_wd  in  REGADDR_W  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  DATA_W  writeback data.
- ex_hi, ex_lo  in  DATA_W each  HI/LO write values.
- ex_whilo  in  1  HI/LO write enable.
- ex_aluop  in  ALUOP_W  opcode, used by MEM for load/store decode.
- ex_mem_addr  in  DATA_W  effective address.
- ex_reg2  in  DATA_W  store data (rt).
- hilo_i  in  2*DATA_W  multi-cycle partial result from execute.
- cnt_i  in  CNT_W  multi-cycle step count from execute.
- mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  same widths as the ex_* inputs  registered stage contents.
- hilo_o  out  2*DATA_W  partial result returned to execute.
- cnt_o  out  CNT_W  step count returned to execute.
- stall_cycles  out  PERF_W  saturating count of cycles in which this stage was stalled.

## Operation
Let S = stall[STAGE_IDX] and D = stall[STAGE_IDX+1]. On each clock edge exactly one action applies, in this priority order:
1. **rst**: all outputs go to zero; mem_aluop = NOP_OP; stall_cycles = 0.
2. **flush**: all mem_* outputs go to zero and mem_aluop = NOP_OP. hilo_o and cnt_o also go to zero, which aborts any in-flight multi-cycle operation. stall_cycles is not cleared.
3. **Bubble** (S=1, D=0): same as the flush values for all mem_*, but hilo_o <= hilo_i and cnt_o <= cnt_i.
4. **Advance** (S=0): every mem_* field takes its ex_* value. hilo_o and cnt_o go to zero.
5. **Hold** (S=1, D=1): all mem_* fields keep their values. hilo_o <= hilo_i and cnt_o <= cnt_i.

Further rules:
- A bubble always has mem_valid=0, mem_wreg=0, mem_whilo=0 and mem_aluop=NOP_OP. Downstream logic never sees a write enable on an invalid entry.
- On advance, mem_wreg and mem_whilo are additionally ANDed with ex_valid.
- stall_cycles increments by 1 on every non-reset edge where S=1, including flush edges. It saturates at 2^PERF_W−1 and does not wrap.
- S=0 together with D=1 is treated as a normal advance. The control unit never generates this combination.

## Timing
- One-cycle latency: inputs sampled at edge n appear on the outputs after edge n.
- All outputs come directly from registers; there is no combinational input-to-output path.
- Reset is synchronous: outputs stay unchanged until the first clk edge with rst=1, then all take their reset values.
- Reset in the middle of a stall or multi-cycle operation discards everything, including hilo_o and cnt_o.
- Flush asserted on the same edge as any stall pattern wins over that stall pattern.
- A multi-cycle op loops hilo_i → hilo_o with one cycle of delay per stalled cycle. The value reaches execute on the next cycle.

## Test plan
- **Reset**: rst=1 for 2 cycles with random inputs → all outputs 0, mem_aluop=NOP_OP, stall_cycles=0.
- **Advance**: stall=0, ex_wd=5'd9, ex_wdata=32'hDEADBEEF, ex_wreg=1, ex_valid=1 → next cycle mem_wd=9, mem_wdata=DEADBEEF, mem_wreg=1, mem_valid=1, hilo_o=0. With ex_valid=0 instead → mem_wreg=0.
- **Bubble then hold**: stall=6'b001000 with hilo_i=64'h1_0000_0002, cnt_i=1 → mem_valid=0, mem_aluop=NOP_OP, hilo_o=64'h1_0000_0002, cnt_o=1. Then stall=6'b011000 with new ex_* values → mem_* unchanged, hilo_o tracks hilo_i.
- **Flush priority**: stall=6'b011000 with flush=1 and mem holding valid data → mem_valid=0, hilo_o=0, cnt_o=0. stall_cycles still increments.
- **Counter saturation**: PERF_W=4, hold S=1 for 20 cycles → stall_cycles reaches 15 and stays at 15. A subsequent rst returns it to 0.
- **Parametrisation**: DATA_W=64, STAGE_IDX=1, STALL_W=4, stall=4'b0010 → bubble. Then stall=4'b0110 → hold. The 64-bit ex_wdata=64'hFFFF_0000_1234_5678 passes through intact once stall=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: carries writeback, HI/LO and load/store fields,
// loops multi-cycle arithmetic state back to execute while stalled, counts stall cycles.
module ex_mem_stage #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         REGADDR_W = 5,
  parameter int unsigned         ALUOP_W   = 8,
  parameter int unsigned         CNT_W     = 2,
  parameter int unsigned         STALL_W   = 6,
  parameter int unsigned         STAGE_IDX = 3,
  parameter logic [ALUOP_W-1:0]  NOP_OP    = '0,
  parameter int unsigned         PERF_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REGADDR_W-1:0]  ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic                  mem_valid,
  output logic [REGADDR_W-1:0]  mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef struct packed {
    logic                 valid;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    logic                 whilo;
    logic [ALUOP_W-1:0]   aluop;
    logic [DATA_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    reg2;
  } stage_t;

  stage_t              stage_q, stage_d, bubble_c, ex_c;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   perf_q, perf_d;
  logic                s_stall, d_stall;
  logic                unused_stall;

  assign s_stall      = stall[STAGE_IDX];
  assign d_stall      = stall[STAGE_IDX+1];
  assign unused_stall = ^stall;

  always_comb begin
    bubble_c       = '0;
    bubble_c.aluop = NOP_OP;
  end

  // Write enables are qualified by valid so an invalid entry never writes downstream.
  always_comb begin
    ex_c.valid    = ex_valid;
    ex_c.wd       = ex_wd;
    ex_c.wreg     = ex_wreg & ex_valid;
    ex_c.wdata    = ex_wdata;
    ex_c.hi       = ex_hi;
    ex_c.lo       = ex_lo;
    ex_c.whilo    = ex_whilo & ex_valid;
    ex_c.aluop    = ex_aluop;
    ex_c.mem_addr = ex_mem_addr;
    ex_c.reg2     = ex_reg2;
  end

  always_comb begin
    stage_d = stage_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    perf_d  = perf_q;
    if (rst) begin
      stage_d = bubble_c;
      hilo_d  = '0;
      cnt_d   = '0;
      perf_d  = '0;
    end else begin
      // Counter runs on every stalled edge, flush included, and sticks at all-ones.
      if (s_stall && (perf_q != '1)) perf_d = perf_q + PERF_W'(1);
      if (flush) begin
        stage_d = bubble_c;
        hilo_d  = '0;
        cnt_d   = '0;
      end else if (s_stall && !d_stall) begin
        stage_d = bubble_c;
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
      end else if (!s_stall) begin
        stage_d = ex_c;
        hilo_d  = '0;
        cnt_d   = '0;
      end else begin
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    hilo_q  <= hilo_d;
    cnt_q   <= cnt_d;
    perf_q  <= perf_d;
  end

  assign mem_valid    = stage_q.valid;
  assign mem_wd       = stage_q.wd;
  assign mem_wreg     = stage_q.wreg;
  assign mem_wdata    = stage_q.wdata;
  assign mem_hi       = stage_q.hi;
  assign mem_lo       = stage_q.lo;
  assign mem_whilo    = stage_q.whilo;
  assign mem_aluop    = stage_q.aluop;
  assign mem_mem_addr = stage_q.mem_addr;
  assign mem_reg2     = stage_q.reg2;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: default build, a 4-bit perf counter build,
// and a 64-bit build with a different stall-vector position.
module tb_ex_mem_stage;

  localparam logic [7:0] NOP = 8'h3C;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [15:0] perf;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, ex_valid, ex_wreg, ex_whilo;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;

  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  logic [15:0] stall_cycles;

  logic        m1_valid, m1_wreg, m1_whilo;
  logic [4:0]  m1_wd;
  logic [31:0] m1_wdata, m1_hi, m1_lo, m1_addr, m1_reg2;
  logic [7:0]  m1_aluop;
  logic [63:0] m1_hilo;
  logic [1:0]  m1_cnt;
  logic [3:0]  perf1;

  logic [3:0]   stall2;
  logic         ex2_valid, ex2_wreg, ex2_whilo;
  logic [4:0]   ex2_wd;
  logic [63:0]  ex2_wdata, ex2_hi, ex2_lo, ex2_addr, ex2_reg2;
  logic [7:0]   ex2_aluop;
  logic [127:0] hilo2_i;
  logic [1:0]   cnt2_i;
  logic         m2_valid, m2_wreg, m2_whilo;
  logic [4:0]   m2_wd;
  logic [63:0]  m2_wdata, m2_hi, m2_lo, m2_addr, m2_reg2;
  logic [7:0]   m2_aluop;
  logic [127:0] hilo2_o;
  logic [1:0]   cnt2_o;
  logic [15:0]  perf2;

  ex_mem_stage #(.NOP_OP(NOP)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .stall_cycles(stall_cycles)
  );

  ex_mem_stage #(.NOP_OP(NOP), .PERF_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_valid(m1_valid), .mem_wd(m1_wd), .mem_wreg(m1_wreg), .mem_wdata(m1_wdata),
    .mem_hi(m1_hi), .mem_lo(m1_lo), .mem_whilo(m1_whilo), .mem_aluop(m1_aluop),
    .mem_mem_addr(m1_addr), .mem_reg2(m1_reg2), .hilo_o(m1_hilo), .cnt_o(m1_cnt),
    .stall_cycles(perf1)
  );

  ex_mem_stage #(.DATA_W(64), .STAGE_IDX(1), .STALL_W(4), .NOP_OP(NOP)) u2 (
    .clk(clk), .rst(rst), .stall(stall2), .flush(1'b0),
    .ex_valid(ex2_valid), .ex_wd(ex2_wd), .ex_wreg(ex2_wreg), .ex_wdata(ex2_wdata),
    .ex_hi(ex2_hi), .ex_lo(ex2_lo), .ex_whilo(ex2_whilo), .ex_aluop(ex2_aluop),
    .ex_mem_addr(ex2_addr), .ex_reg2(ex2_reg2), .hilo_i(hilo2_i), .cnt_i(cnt2_i),
    .mem_valid(m2_valid), .mem_wd(m2_wd), .mem_wreg(m2_wreg), .mem_wdata(m2_wdata),
    .mem_hi(m2_hi), .mem_lo(m2_lo), .mem_whilo(m2_whilo), .mem_aluop(m2_aluop),
    .mem_mem_addr(m2_addr), .mem_reg2(m2_reg2), .hilo_o(hilo2_o), .cnt_o(cnt2_o),
    .stall_cycles(perf2)
  );

  int   total = 0;
  int   bad   = 0;
  obs_t mdl;
  obs_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.valid = mem_valid;    o.wd    = mem_wd;     o.wreg  = mem_wreg;
    o.wdata = mem_wdata;    o.hi    = mem_hi;     o.lo    = mem_lo;
    o.whilo = mem_whilo;    o.aluop = mem_aluop;  o.addr  = mem_mem_addr;
    o.reg2  = mem_reg2;     o.hilo  = hilo_o;     o.cnt   = cnt_o;
    o.perf  = stall_cycles;
    return o;
  endfunction

  task automatic rand_ex();
    ex_valid    = 1'($urandom);
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_whilo    = 1'($urandom);
    ex_aluop    = 8'($urandom);
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    hilo_i      = {$urandom, $urandom} | 64'h1;
    cnt_i       = 2'($urandom);
  endtask

  // Expected stage contents after an advance edge, from the values being driven now.
  function automatic obs_t adv_exp(input logic [15:0] perf);
    obs_t e;
    e.valid = ex_valid;   e.wd = ex_wd;   e.wreg = ex_wreg & ex_valid;
    e.wdata = ex_wdata;   e.hi = ex_hi;   e.lo = ex_lo;
    e.whilo = ex_whilo & ex_valid;        e.aluop = ex_aluop;
    e.addr  = ex_mem_addr; e.reg2 = ex_reg2;
    e.hilo  = '0;         e.cnt = '0;     e.perf = perf;
    return e;
  endfunction

  function automatic obs_t bub_exp(input logic [63:0] h, input logic [1:0] c, input logic [15:0] perf);
    obs_t e;
    e = '0;
    e.aluop = NOP;
    e.hilo  = h;
    e.cnt   = c;
    e.perf  = perf;
    return e;
  endfunction

  task automatic test_reset();
    obs_t e, o;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_ex();
      stall = 6'($urandom);
      flush = 1'($urandom);
      exp_q.push_back(bub_exp('0, '0, '0));
      tick();
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL reset[%0d] got=%h want=%h", i, o, e); end
    end
    total++;
    if (perf1 !== 4'd0) begin bad++; $display("FAIL reset_perf1 got=%0d want=0", perf1); end
    total++;
    if ({m2_valid, m2_aluop, perf2} !== {1'b0, NOP, 16'd0}) begin
      bad++; $display("FAIL reset_u2 got=%h want=%h", {m2_valid, m2_aluop, perf2}, {1'b0, NOP, 16'd0});
    end
    mdl = e;
    rst = 1'b0;
  endtask

  task automatic test_advance();
    obs_t e, o;
    stall = '0; flush = 1'b0;
    rand_ex();
    ex_wd = 5'd9; ex_wdata = 32'hDEADBEEF; ex_wreg = 1'b1; ex_valid = 1'b1;
    mdl = adv_exp(mdl.perf); exp_q.push_back(mdl);
    tick();
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL advance_valid got=%h want=%h", o, e); end
    rand_ex();
    ex_valid = 1'b0; ex_wreg = 1'b1; ex_whilo = 1'b1;
    mdl = adv_exp(mdl.perf); exp_q.push_back(mdl);
    tick();
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL advance_invalid got=%h want=%h", o, e); end
    total++;
    if ({mem_wreg, mem_whilo} !== 2'b00) begin
      bad++; $display("FAIL advance_invalid_we got=%b want=00", {mem_wreg, mem_whilo});
    end
  endtask

  task automatic test_bubble_hold();
    obs_t e, o;
    flush = 1'b0;
    rand_ex();
    stall = '0; ex_valid = 1'b1; ex_wreg = 1'b1; ex_whilo = 1'b1;
    mdl = adv_exp(mdl.perf); exp_q.push_back(mdl);
    tick();
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL bh_advance got=%h want=%h", o, e); end
    for (int i = 0; i < 6; i++) begin
      rand_ex();
      if (i == 3) begin
        stall = 6'b001000; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
        mdl = bub_exp(hilo_i, cnt_i, mdl.perf + 16'd1);
      end else begin
        stall = 6'b011000;
        mdl.hilo = hilo_i; mdl.cnt = cnt_i; mdl.perf = mdl.perf + 16'd1;
      end
      exp_q.push_back(mdl);
      tick();
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL bubble_hold[%0d] got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_flush();
    obs_t e, o;
    logic [5:0] pats [3];
    pats[0] = 6'b011000; pats[1] = 6'b000000; pats[2] = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      stall = '0; flush = 1'b0; ex_valid = 1'b1; ex_wreg = 1'b1;
      mdl = adv_exp(mdl.perf); exp_q.push_back(mdl);
      tick();
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL flush_pre[%0d] got=%h want=%h", i, o, e); end
      rand_ex();
      stall = pats[i]; flush = 1'b1;
      mdl = bub_exp('0, '0, pats[i][3] ? mdl.perf + 16'd1 : mdl.perf);
      exp_q.push_back(mdl);
      tick();
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL flush[%0d] got=%h want=%h", i, o, e); end
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    stall = '0; flush = 1'b0;
    rand_ex();
    exp_q.push_back(adv_exp(mdl.perf));
    for (int i = 0; i < 8; i++) begin
      tick();
      rand_ex();
      if (i < 7) exp_q.push_back(adv_exp(mdl.perf));
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, o, e); end
    end
    mdl = e;
  endtask

  task automatic test_saturation();
    obs_t e, o;
    logic [3:0] p1;
    rst = 1'b1; flush = 1'b0;
    rand_ex();
    mdl = bub_exp('0, '0, '0); exp_q.push_back(mdl);
    tick();
    e = exp_q.pop_front(); o = observe(); total++;
    if (o !== e) begin bad++; $display("FAIL sat_reset got=%h want=%h", o, e); end
    rst = 1'b0;
    p1 = 4'd0;
    for (int i = 0; i < 20; i++) begin
      rand_ex();
      stall = 6'b011000;
      mdl.hilo = hilo_i; mdl.cnt = cnt_i; mdl.perf = mdl.perf + 16'd1;
      if (p1 != 4'd15) p1 = p1 + 4'd1;
      exp_q.push_back(mdl);
      tick();
      e = exp_q.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL sat_u0[%0d] got=%h want=%h", i, o, e); end
      total++;
      if (perf1 !== p1) begin bad++; $display("FAIL sat_perf1[%0d] got=%0d want=%0d", i, perf1, p1); end
    end
    rst = 1'b1;
    tick();
    total++;
    if (perf1 !== 4'd0) begin bad++; $display("FAIL sat_rst_perf1 got=%0d want=0", perf1); end
    rst = 1'b0; stall = '0;
    mdl = bub_exp('0, '0, '0);
  endtask

  task automatic test_param64();
    logic [127:0] h;
    ex2_valid = 1'b1; ex2_wreg = 1'b1; ex2_whilo = 1'b0; ex2_wd = 5'd3;
    ex2_wdata = 64'h0123_4567_89AB_CDEF; ex2_aluop = 8'h21;
    stall2 = 4'b0000;
    tick();
    total++;
    if ({m2_valid, m2_wdata, m2_aluop} !== {1'b1, 64'h0123_4567_89AB_CDEF, 8'h21}) begin
      bad++; $display("FAIL p64_adv got=%h want=%h", {m2_valid, m2_wdata, m2_aluop}, {1'b1, 64'h0123_4567_89AB_CDEF, 8'h21});
    end
    h = {$urandom, $urandom, $urandom, $urandom};
    hilo2_i = h; cnt2_i = 2'd2; stall2 = 4'b0010;
    tick();
    total++;
    if ({m2_valid, m2_wreg, m2_wdata, m2_aluop, hilo2_o, cnt2_o, perf2} !== {1'b0, 1'b0, 64'd0, NOP, h, 2'd2, 16'd1}) begin
      bad++; $display("FAIL p64_bubble got=%h want=%h", {m2_valid, m2_wreg, m2_wdata, m2_aluop, hilo2_o, cnt2_o, perf2}, {1'b0, 1'b0, 64'd0, NOP, h, 2'd2, 16'd1});
    end
    h = {$urandom, $urandom, $urandom, $urandom};
    hilo2_i = h; cnt2_i = 2'd3; stall2 = 4'b0110;
    ex2_wdata = 64'hAAAA_5555_AAAA_5555; ex2_aluop = 8'h77;
    tick();
    total++;
    if ({m2_valid, m2_wdata, m2_aluop, hilo2_o, cnt2_o, perf2} !== {1'b0, 64'd0, NOP, h, 2'd3, 16'd2}) begin
      bad++; $display("FAIL p64_hold got=%h want=%h", {m2_valid, m2_wdata, m2_aluop, hilo2_o, cnt2_o, perf2}, {1'b0, 64'd0, NOP, h, 2'd3, 16'd2});
    end
    ex2_wdata = 64'hFFFF_0000_1234_5678; stall2 = 4'b0000;
    tick();
    total++;
    if ({m2_valid, m2_wreg, m2_wdata, m2_aluop, hilo2_o, perf2} !== {1'b1, 1'b1, 64'hFFFF_0000_1234_5678, 8'h77, 128'd0, 16'd2}) begin
      bad++; $display("FAIL p64_pass got=%h want=%h", {m2_valid, m2_wreg, m2_wdata, m2_aluop, hilo2_o, perf2}, {1'b1, 1'b1, 64'hFFFF_0000_1234_5678, 8'h77, 128'd0, 16'd2});
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    rand_ex();
    stall2 = '0; ex2_valid = 1'b0; ex2_wreg = 1'b0; ex2_whilo = 1'b0; ex2_wd = '0;
    ex2_wdata = '0; ex2_hi = 64'h1111; ex2_lo = 64'h2222; ex2_addr = 64'h3333;
    ex2_reg2 = 64'h4444; ex2_aluop = '0; hilo2_i = '0; cnt2_i = '0;
    test_reset();
    test_advance();
    test_bubble_hold();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_param64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
